// File: rtl/rv32_alu_if.sv
// Operand/result bundle for rv32_alu.
// ZERO and ZERO_Q exist only when ALU_ZERO_FLAG_EN is defined.
interface rv32_alu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ALU_CNTR_W = 4
);
  logic [DATA_WIDTH-1:0] s1;
  logic [DATA_WIDTH-1:0] s2;
  logic [ALU_CNTR_W-1:0] ALU_CNTR;
  logic [DATA_WIDTH-1:0] ALU_OUT;
  logic [DATA_WIDTH-1:0] ALU_OUT_Q;
`ifdef ALU_ZERO_FLAG_EN
  logic                  ZERO;
  logic                  ZERO_Q;

  modport master (
    output s1, s2, ALU_CNTR,
    input  ALU_OUT, ALU_OUT_Q, ZERO, ZERO_Q
  );
  modport slave (
    input  s1, s2, ALU_CNTR,
    output ALU_OUT, ALU_OUT_Q, ZERO, ZERO_Q
  );
`else
  modport master (
    output s1, s2, ALU_CNTR,
    input  ALU_OUT, ALU_OUT_Q
  );
  modport slave (
    input  s1, s2, ALU_CNTR,
    output ALU_OUT, ALU_OUT_Q
  );
`endif
endinterface

// File: rtl/rv32_alu.sv
// RV32IM execute-stage ALU: 16 ops, combinational ALU_OUT plus registered ALU_OUT_Q.
// Optional macro ALU_ZERO_FLAG_EN adds ZERO / ZERO_Q result-is-zero flags.
module rv32_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int ALU_CNTR_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  rv32_alu_if.slave bus
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_OR   = 4'b0010,
    OP_AND  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_EQ   = 4'b1010,
    OP_GE   = 4'b1011,
    OP_LT   = 4'b1100,
    OP_NE   = 4'b1101,
    OP_LTU  = 4'b1110,
    OP_GEU  = 4'b1111
  } alu_op_e;

  // Comparison results occupy bit 0 only.
  function automatic logic [DATA_WIDTH-1:0] flag_word(input logic flag);
    return {{(DATA_WIDTH-1){1'b0}}, flag};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_left(
    input logic [DATA_WIDTH-1:0] a,
    input logic [SHAMT_W-1:0]    sh
  );
    return a << sh;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_right(
    input logic [DATA_WIDTH-1:0] a,
    input logic [SHAMT_W-1:0]    sh,
    input logic                  arith
  );
    logic signed [DATA_WIDTH-1:0] a_s;
    a_s = a;
    if (arith) return a_s >>> sh;
    return a >> sh;
  endfunction

  alu_op_e                      op;
  logic        [SHAMT_W-1:0]    shamt;
  logic signed [DATA_WIDTH-1:0] s1_s;
  logic signed [DATA_WIDTH-1:0] s2_s;
  logic                         lt_s;
  logic                         lt_u;
  logic                         eq;
  logic        [DATA_WIDTH-1:0] alu_out_p0;
  logic        [DATA_WIDTH-1:0] alu_out_p1;

  assign op    = alu_op_e'(bus.ALU_CNTR);
  assign shamt = bus.s2[SHAMT_W-1:0];
  assign s1_s  = bus.s1;
  assign s2_s  = bus.s2;
  assign lt_s  = s1_s < s2_s;
  assign lt_u  = bus.s1 < bus.s2;
  assign eq    = bus.s1 == bus.s2;

  // Stage p0: combinational result, independent of reset
  always_comb begin
    alu_out_p0 = '0;
    case (op)
      OP_ADD:  alu_out_p0 = bus.s1 + bus.s2;
      OP_SUB:  alu_out_p0 = bus.s1 - bus.s2;
      OP_OR:   alu_out_p0 = bus.s1 | bus.s2;
      OP_AND:  alu_out_p0 = bus.s1 & bus.s2;
      OP_XOR:  alu_out_p0 = bus.s1 ^ bus.s2;
      OP_SLL:  alu_out_p0 = shift_left(bus.s1, shamt);
      OP_SRL:  alu_out_p0 = shift_right(bus.s1, shamt, 1'b0);
      OP_SRA:  alu_out_p0 = shift_right(bus.s1, shamt, 1'b1);
      OP_SLT:  alu_out_p0 = flag_word(lt_s);
      OP_SLTU: alu_out_p0 = flag_word(lt_u);
      OP_EQ:   alu_out_p0 = flag_word(eq);
      OP_GE:   alu_out_p0 = flag_word(!lt_s);
      OP_LT:   alu_out_p0 = flag_word(lt_s);
      OP_NE:   alu_out_p0 = flag_word(!eq);
      OP_LTU:  alu_out_p0 = flag_word(lt_u);
      OP_GEU:  alu_out_p0 = flag_word(!lt_u);
      default: alu_out_p0 = '0;
    endcase
  end

  // Stage p1: registered copy, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_out_p1 <= '0;
    else        alu_out_p1 <= alu_out_p0;
  end

  assign bus.ALU_OUT   = alu_out_p0;
  assign bus.ALU_OUT_Q = alu_out_p1;

`ifdef ALU_ZERO_FLAG_EN
  logic zero_p0;
  logic zero_p1;

  assign zero_p0 = (alu_out_p0 == '0);

  // Resets high so it agrees with the cleared result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_p1 <= 1'b1;
    else        zero_p1 <= zero_p0;
  end

  assign bus.ZERO   = zero_p0;
  assign bus.ZERO_Q = zero_p1;
`endif

endmodule

// File: tb/tb_rv32_alu.sv
// Self-checking bench for rv32_alu: directed vector table, reset/register sequence,
// and randomized operations against an arithmetic reference model.
module tb_rv32_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  rv32_alu_if #(.DATA_WIDTH(32), .ALU_CNTR_W(4)) bus ();

  rv32_alu #(.DATA_WIDTH(32), .ALU_CNTR_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input string n, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model using whole-number arithmetic on 64-bit values.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint ua, ub, sa, sb, p, r;
    int sh;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(ub % 32);
    p  = 1;
    for (int k = 0; k < sh; k++) p = p * 2;
    r  = 0;
    case (op)
      4'd0:  r = ua + ub;
      4'd1:  r = ua - ub;
      4'd2:  r = longint'({32'd0, a | b});
      4'd3:  r = longint'({32'd0, a & b});
      4'd4:  r = longint'({32'd0, a ^ b});
      4'd5:  r = ua * p;
      4'd6:  r = ua / p;
      4'd7:  r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      4'd8:  r = (sa < sb) ? 1 : 0;
      4'd9:  r = (ua < ub) ? 1 : 0;
      4'd10: r = (ua == ub) ? 1 : 0;
      4'd11: r = (sa >= sb) ? 1 : 0;
      4'd12: r = (sa < sb) ? 1 : 0;
      4'd13: r = (ua != ub) ? 1 : 0;
      4'd14: r = (ua < ub) ? 1 : 0;
      default: r = (ua >= ub) ? 1 : 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ALU_CNTR = op;
    bus.s1       = a;
    bus.s2       = b;
    #1;
  endtask

  initial begin
    bus.ALU_CNTR = 4'd0;
    bus.s1       = 32'd0;
    bus.s2       = 32'd0;

    tv.push_back(mk("add_wrap",   4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000));
    tv.push_back(mk("add_neg",    4'd0,  32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFC));
    tv.push_back(mk("sub_neg",    4'd1,  32'd10,       32'd30,       32'hFFFFFFEC));
    tv.push_back(mk("sub_zero",   4'd1,  32'd0,        32'd0,        32'h00000000));
    tv.push_back(mk("or_all",     4'd2,  32'hFF00FF00, 32'h00FF00FF, 32'hFFFFFFFF));
    tv.push_back(mk("and_none",   4'd3,  32'hFF00FF00, 32'h00FF00FF, 32'h00000000));
    tv.push_back(mk("xor_self",   4'd4,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000));
    tv.push_back(mk("and_mask",   4'd3,  32'hFFFFFFFF, 32'h12345678, 32'h12345678));
    tv.push_back(mk("sll_31",     4'd5,  32'd1,        32'd31,       32'h80000000));
    tv.push_back(mk("sll_0",      4'd5,  32'hDEADBEEF, 32'd0,        32'hDEADBEEF));
    tv.push_back(mk("srl_31",     4'd6,  32'h80000000, 32'd31,       32'h00000001));
    tv.push_back(mk("sra_neg",    4'd7,  32'h80000000, 32'd4,        32'hF8000000));
    tv.push_back(mk("sra_pos",    4'd7,  32'h7FFFFFFF, 32'd4,        32'h07FFFFFF));
    tv.push_back(mk("sra_m1",     4'd7,  32'hFFFFFFFF, 32'd31,       32'hFFFFFFFF));
    tv.push_back(mk("sll_hi_s2",  4'd5,  32'd1,        32'h00000024, 32'h00000010));
    tv.push_back(mk("slt_m1_1",   4'd8,  32'hFFFFFFFF, 32'd1,        32'd1));
    tv.push_back(mk("sltu_m1_1",  4'd9,  32'hFFFFFFFF, 32'd1,        32'd0));
    tv.push_back(mk("ltu_m1_1",   4'd14, 32'hFFFFFFFF, 32'd1,        32'd0));
    tv.push_back(mk("geu_m1_1",   4'd15, 32'hFFFFFFFF, 32'd1,        32'd1));
    tv.push_back(mk("lt_min_0",   4'd12, 32'h80000000, 32'd0,        32'd1));
    tv.push_back(mk("ge_m1_0",    4'd11, 32'hFFFFFFFF, 32'd0,        32'd0));
    tv.push_back(mk("ge_eq",      4'd11, 32'd10,       32'd10,       32'd1));
    tv.push_back(mk("eq_true",    4'd10, 32'd42,       32'd42,       32'd1));
    tv.push_back(mk("eq_false",   4'd10, 32'd42,       32'd99,       32'd0));
    tv.push_back(mk("ne_true",    4'd13, 32'd42,       32'd99,       32'd1));
    tv.push_back(mk("ne_false",   4'd13, 32'd42,       32'd42,       32'd0));
    tv.push_back(mk("eq_zero",    4'd10, 32'd0,        32'd0,        32'd1));

    // Reset state: register cleared while rst_n low, comb output live
    apply(4'd0, 32'd3, 32'd4);
    check("reset_q", bus.ALU_OUT_Q, 32'd0);
    check("reset_comb", bus.ALU_OUT, 32'd7);
`ifdef ALU_ZERO_FLAG_EN
    check("reset_zero_q", {31'd0, bus.ZERO_Q}, 32'd1);
`endif
    @(posedge clk);
    #1 check("reset_q_hold", bus.ALU_OUT_Q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, combinational result
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      apply(tv[i].op, tv[i].a, tv[i].b);
      check(tv[i].name, bus.ALU_OUT, tv[i].exp);
    end

    // Register latency, async reset mid-cycle, reload
    @(negedge clk);
    apply(4'd0, 32'd10, 32'd20);
    check("q_before_edge", bus.ALU_OUT_Q, tv[tv.size()-1].exp);
    @(posedge clk);
    #1 check("q_after_edge", bus.ALU_OUT_Q, 32'd30);
    #2 rst_n = 1'b0;
    #1 check("q_async_clear", bus.ALU_OUT_Q, 32'd0);
    check("comb_in_reset", bus.ALU_OUT, 32'd30);
    @(posedge clk);
    #1 check("q_stays_reset", bus.ALU_OUT_Q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("q_after_release", bus.ALU_OUT_Q, 32'd0);
    @(posedge clk);
    #1 check("q_reload", bus.ALU_OUT_Q, 32'd30);

`ifdef ALU_ZERO_FLAG_EN
    @(negedge clk);
    apply(4'd1, 32'd5, 32'd5);
    check("zero_sub", {31'd0, bus.ZERO}, 32'd1);
    @(posedge clk);
    #1 check("zero_q_sub", {31'd0, bus.ZERO_Q}, 32'd1);
    @(negedge clk);
    apply(4'd0, 32'd5, 32'd5);
    check("zero_nonzero", {31'd0, bus.ZERO}, 32'd0);
    @(posedge clk);
    #1 check("zero_q_nonzero", {31'd0, bus.ZERO_Q}, 32'd0);
`endif

    // Randomized ops against the reference model, comb and registered
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b, e;
      op = 4'($urandom_range(0, 15));
      a  = pick_operand();
      b  = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      e  = model(op, a, b);
      @(negedge clk);
      apply(op, a, b);
      check($sformatf("rand_comb op=%0d a=%08h b=%08h", op, a, b), bus.ALU_OUT, e);
      @(posedge clk);
      #1 check($sformatf("rand_q op=%0d a=%08h b=%08h", op, a, b), bus.ALU_OUT_Q, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
